skinny_sbox_share_compress: RTL

- Downstream stage of the 18 per-coordinate 3-share component-function instances (term index num = 0..17) of the second-order masked SKINNY S-box.
- Registers all raw partial terms as a glitch barrier, then compresses them into 3 output shares per coordinate, and registers the result.
- Uses an elastic valid/ready 2-stage pipeline, plus a processed-S-box counter for round control.

---
 rtl/skinny_sbox_share_compress.sv | 93 +++++++++
 1 files changed

// File: rtl/skinny_sbox_share_compress.sv
// Registers raw masked S-box partial terms, XOR-compresses them to 3 shares per coordinate.
// Latency 2 cycles, 1 item/cycle; elastic valid/ready, stages hold and in_ready drops under stall.
module skinny_sbox_share_compress #(
    parameter int NCOORD  = 4,
    parameter int COUNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [18*NCOORD-1:0]  cf_terms,
    input  logic                  flush,
    input  logic                  cnt_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCOORD-1:0]     out_share1,
    output logic [NCOORD-1:0]     out_share2,
    output logic [NCOORD-1:0]     out_share3,
    output logic [COUNT_W-1:0]    sbox_count
);

    logic                 a_vld;
    logic                 b_vld;
    logic [18*NCOORD-1:0] terms_q;
    logic [NCOORD-1:0]    share1_q, share2_q, share3_q;
    logic [NCOORD-1:0]    share1_d, share2_d, share3_d;
    logic                 b_free;
    logic                 a_adv;
    logic                 accept;
    logic                 out_xfer;

    assign b_free    = !b_vld || out_ready;
    assign a_adv     = a_vld && b_free;
    assign in_ready  = (!a_vld || b_free) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_xfer  = b_vld && out_ready;
    assign out_valid = b_vld;

    assign out_share1 = share1_q;
    assign out_share2 = share2_q;
    assign out_share3 = share3_q;

    // Compression reads only the registered terms so no glitch on cf_terms can reach a share.
    always_comb begin
        share1_d = '0;
        share2_d = '0;
        share3_d = '0;
        for (int c = 0; c < NCOORD; c++) begin
            share1_d[c] = ^{terms_q[18*c +: 3], terms_q[18*c + 9  +: 3]};
            share2_d[c] = ^{terms_q[18*c + 3 +: 3], terms_q[18*c + 12 +: 3]};
            share3_d[c] = ^{terms_q[18*c + 6 +: 3], terms_q[18*c + 15 +: 3]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_vld      <= 1'b0;
            b_vld      <= 1'b0;
            terms_q    <= '0;
            share1_q   <= '0;
            share2_q   <= '0;
            share3_q   <= '0;
            sbox_count <= '0;
        end else begin
            if (flush) begin
                a_vld <= 1'b0;
                b_vld <= 1'b0;
            end else begin
                if (accept)
                    a_vld <= 1'b1;
                else if (a_adv)
                    a_vld <= 1'b0;
                if (a_adv)
                    b_vld <= 1'b1;
                else if (out_xfer)
                    b_vld <= 1'b0;
            end
            if (accept)
                terms_q <= cf_terms;
            if (a_adv && !flush) begin
                share1_q <= share1_d;
                share2_q <= share2_d;
                share3_q <= share3_d;
            end
            // A transfer in the same cycle as a clear is intentionally dropped.
            if (cnt_clr)
                sbox_count <= '0;
            else if (out_xfer)
                sbox_count <= sbox_count + COUNT_W'(1);
        end
    end

endmodule
